drum_step_sequencer: RTL and testbench

- 16-step pattern sequencer that drives the drum voices (kick, snare, closed hat, open hat) from the audio tick domain.
- Holds a writable pattern bit-matrix and divides audio_tick into steps.
- Emits one-tick trigger pulses per voice, plus the open-hat choke when the closed hat fires.
- Sits between the control/UI logic and the voice modules; the mixer is downstream of the voices.

---
 rtl/drum_step_sequencer_pkg.sv | 20 ++
 rtl/drum_step_sequencer_if.sv | 37 +++
 rtl/drum_step_sequencer_step_timer.sv | 93 +++++++++
 rtl/drum_step_sequencer.sv | 90 +++++++++
 tb/tb_drum_step_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/drum_step_sequencer_pkg.sv
// Shared definitions for the drum step sequencer.
//   - Default pattern geometry (NUM_VOICES x NUM_STEPS).
//   - Voice lane indices for the drum kit.
//   - Play/stop state encoding used by the step timer.
package drum_pkg;

    localparam int unsigned NUM_VOICES = 4;
    localparam int unsigned NUM_STEPS  = 16;

    localparam int unsigned KICK  = 0;
    localparam int unsigned SNARE = 1;
    localparam int unsigned CHH   = 2;
    localparam int unsigned OHH   = 3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PLAY = 1'b1
    } seq_state_t;

endpackage

// File: rtl/drum_step_sequencer_if.sv
// Control/UI <-> sequencer bundle.
//   master: control logic (drives run, tempo, mute, pattern writes;
//           observes triggers, choke and step position)
//   slave : drum_step_sequencer
// Signals:
//   run, ticks_per_step, mute            transport and voice gating
//   wr_en, wr_voice, wr_step, wr_data    pattern bit write port
//   trig, choke, step_idx, step_strobe   sequencer outputs
interface drum_step_sequencer_if #(
    parameter int unsigned NUM_VOICES = drum_pkg::NUM_VOICES,
    parameter int unsigned NUM_STEPS  = drum_pkg::NUM_STEPS,
    parameter int unsigned TEMPO_W    = 16
);

    logic                          run;
    logic [TEMPO_W-1:0]            ticks_per_step;
    logic [NUM_VOICES-1:0]         mute;
    logic                          wr_en;
    logic [$clog2(NUM_VOICES)-1:0] wr_voice;
    logic [$clog2(NUM_STEPS)-1:0]  wr_step;
    logic                          wr_data;
    logic [NUM_VOICES-1:0]         trig;
    logic                          choke;
    logic [$clog2(NUM_STEPS)-1:0]  step_idx;
    logic                          step_strobe;

    modport master (
        output run, ticks_per_step, mute, wr_en, wr_voice, wr_step, wr_data,
        input  trig, choke, step_idx, step_strobe
    );

    modport slave (
        input  run, ticks_per_step, mute, wr_en, wr_voice, wr_step, wr_data,
        output trig, choke, step_idx, step_strobe
    );

endinterface

// File: rtl/drum_step_sequencer_step_timer.sv
// Step timer: play/stop state, audio-tick divider and step position.
// Ports:
//   audio_tick     clock, one edge per audio sample
//   reset          synchronous active-high reset
//   run_i          1 = play, 0 = stop
//   tps_i          audio ticks per step (0 and 1 both mean 1)
//   fire_o         combinational: this edge fires the column at step_idx_o
//   step_idx_o     current step position
//   step_strobe_o  registered one-tick pulse at each step start
module step_timer
    import drum_pkg::*;
#(
    parameter int unsigned STEP_COUNT = 16,
    parameter int unsigned TEMPO_W    = 16
) (
    input  logic                          audio_tick,
    input  logic                          reset,
    input  logic                          run_i,
    input  logic [TEMPO_W-1:0]            tps_i,
    output logic                          fire_o,
    output logic [$clog2(STEP_COUNT)-1:0] step_idx_o,
    output logic                          step_strobe_o
);

    localparam int unsigned SW = $clog2(STEP_COUNT);

    seq_state_t         state_q, state_d;
    logic [TEMPO_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [TEMPO_W-1:0] tps_eff;
    logic [SW-1:0]      step_q, step_d;
    logic               strobe_q, strobe_d;
    logic               fire;

    always_comb begin
        tps_eff    = (tps_i == '0) ? TEMPO_W'(1) : tps_i;
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        step_d     = step_q;
        strobe_d   = 1'b0;
        fire       = 1'b0;
        case (state_q)
            IDLE: begin
                tick_cnt_d = '0;
                step_d     = '0;
                if (run_i) begin
                    state_d = PLAY;
                end
            end
            PLAY: begin
                if (!run_i) begin
                    state_d    = IDLE;
                    tick_cnt_d = '0;
                    step_d     = '0;
                end else begin
                    fire     = (tick_cnt_q == '0);
                    strobe_d = fire;
                    // >= rather than == so a tempo decrease below the
                    // current count ends the step immediately.
                    if (tick_cnt_q >= tps_eff - TEMPO_W'(1)) begin
                        tick_cnt_d = '0;
                        step_d     = step_q + SW'(1);
                    end else begin
                        tick_cnt_d = tick_cnt_q + TEMPO_W'(1);
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                tick_cnt_d = '0;
                step_d     = '0;
            end
        endcase
    end

    always_ff @(posedge audio_tick) begin
        if (reset) begin
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            step_q     <= '0;
            strobe_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            step_q     <= step_d;
            strobe_q   <= strobe_d;
        end
    end

    assign fire_o        = fire;
    assign step_idx_o    = step_q;
    assign step_strobe_o = strobe_q;

endmodule

// File: rtl/drum_step_sequencer.sv
// 16-step drum pattern sequencer clocked from the audio tick.
// Holds the voice x step pattern matrix, fires one column per step and
// emits one-tick trigger pulses per voice plus the open-hat choke.
// Ports:
//   audio_tick  clock, one edge per audio sample
//   reset       synchronous active-high reset (also clears the pattern)
//   bus         drum_step_sequencer_if.slave: transport, tempo, mute,
//               pattern write port, trig/choke/step_idx/step_strobe
module drum_step_sequencer #(
    parameter int unsigned NUM_VOICES = drum_pkg::NUM_VOICES,
    parameter int unsigned NUM_STEPS  = drum_pkg::NUM_STEPS,
    parameter int unsigned TEMPO_W    = 16,
    parameter int unsigned CHH_IDX    = drum_pkg::CHH,
    parameter int unsigned OHH_IDX    = drum_pkg::OHH
) (
    input  logic                   audio_tick,
    input  logic                   reset,
    drum_step_sequencer_if.slave   bus
);

    localparam int unsigned SW = $clog2(NUM_STEPS);

    logic [NUM_STEPS-1:0]  pattern_q [NUM_VOICES];
    logic [NUM_VOICES-1:0] col;
    logic [NUM_VOICES-1:0] eff;
    logic [NUM_VOICES-1:0] trig_q, trig_d;
    logic                  choke_q, choke_d;
    logic                  fire;
    logic [SW-1:0]         step_idx;
    logic                  step_strobe;

    step_timer #(
        .STEP_COUNT (NUM_STEPS),
        .TEMPO_W    (TEMPO_W)
    ) u_timer (
        .audio_tick    (audio_tick),
        .reset         (reset),
        .run_i         (bus.run),
        .tps_i         (bus.ticks_per_step),
        .fire_o        (fire),
        .step_idx_o    (step_idx),
        .step_strobe_o (step_strobe)
    );

    // Column read uses the pre-edge pattern, so a write landing on the
    // firing column in the same edge only shows up on the next pass.
    always_comb begin
        for (int unsigned v = 0; v < NUM_VOICES; v++) begin
            col[v] = pattern_q[v][step_idx];
        end
        eff     = col & ~bus.mute;
        trig_d  = '0;
        choke_d = 1'b0;
        if (fire) begin
            trig_d = eff;
            // Closed hat wins over open hat and chokes it.
            if (eff[CHH_IDX]) begin
                trig_d[OHH_IDX] = 1'b0;
                choke_d         = 1'b1;
            end
        end
    end

    always_ff @(posedge audio_tick) begin
        if (reset) begin
            for (int unsigned v = 0; v < NUM_VOICES; v++) begin
                pattern_q[v] <= '0;
            end
            trig_q  <= '0;
            choke_q <= 1'b0;
        end else begin
            trig_q  <= trig_d;
            choke_q <= choke_d;
            if (bus.wr_en) begin
                // Matching against each valid row drops out-of-range voices.
                for (int unsigned v = 0; v < NUM_VOICES; v++) begin
                    if (32'(bus.wr_voice) == v) begin
                        pattern_q[v][bus.wr_step] <= bus.wr_data;
                    end
                end
            end
        end
    end

    assign bus.trig        = trig_q;
    assign bus.choke       = choke_q;
    assign bus.step_idx    = step_idx;
    assign bus.step_strobe = step_strobe;

endmodule

// File: tb/tb_drum_step_sequencer.sv
// Directed self-checking bench for drum_step_sequencer.
module tb_drum_step_sequencer;

    localparam int unsigned NV = 4;
    localparam int unsigned NS = 16;
    localparam int unsigned TW = 16;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    drum_step_sequencer_if #(.NUM_VOICES(NV), .NUM_STEPS(NS), .TEMPO_W(TW)) bus ();

    drum_step_sequencer #(
        .NUM_VOICES (NV),
        .NUM_STEPS  (NS),
        .TEMPO_W    (TW),
        .CHH_IDX    (2),
        .OHH_IDX    (3)
    ) dut (
        .audio_tick (clk),
        .reset      (rst),
        .bus        (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst                = 1'b1;
        bus.run            = 1'b0;
        bus.ticks_per_step = '0;
        bus.mute           = '0;
        bus.wr_en          = 1'b0;
        bus.wr_voice       = '0;
        bus.wr_step        = '0;
        bus.wr_data        = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic write_bit(input int v, input int s, input logic d);
        bus.wr_en    = 1'b1;
        bus.wr_voice = 2'(v);
        bus.wr_step  = 4'(s);
        bus.wr_data  = d;
        tick();
        bus.wr_en    = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.trig !== 4'b0000 || bus.choke !== 1'b0 || bus.step_idx !== 4'd0 || bus.step_strobe !== 1'b0) begin
            failures++;
            $display("FAIL reset_state trig=%b choke=%b step=%0d strobe=%b expected 0000/0/0/0",
                     bus.trig, bus.choke, bus.step_idx, bus.step_strobe);
        end
        for (int n = 0; n < 3; n++) begin
            tick();
            checks++;
            if (bus.trig !== 4'b0000 || bus.step_idx !== 4'd0 || bus.step_strobe !== 1'b0) begin
                failures++;
                $display("FAIL idle_hold tick=%0d trig=%b step=%0d strobe=%b expected 0000/0/0",
                         n, bus.trig, bus.step_idx, bus.step_strobe);
            end
        end
    endtask

    task automatic test_kick_pattern();
        logic [3:0] exp_trig;
        logic       exp_strobe;
        logic [3:0] exp_step;
        do_reset();
        write_bit(0, 0, 1'b1);
        write_bit(0, 4, 1'b1);
        write_bit(0, 8, 1'b1);
        write_bit(0, 12, 1'b1);
        bus.ticks_per_step = 16'd4;
        bus.run = 1'b1;
        tick();  // run sampled, enters PLAY
        for (int n = 1; n <= 70; n++) begin
            tick();
            exp_strobe = ((n - 1) % 4 == 0);
            exp_trig   = ((n - 1) % 16 == 0) ? 4'b0001 : 4'b0000;
            exp_step   = 4'((n / 4) % 16);
            checks++;
            if (bus.trig !== exp_trig || bus.step_strobe !== exp_strobe || bus.step_idx !== exp_step) begin
                failures++;
                $display("FAIL kick_pattern n=%0d trig=%b strobe=%b step=%0d expected %b/%b/%0d",
                         n, bus.trig, bus.step_strobe, bus.step_idx, exp_trig, exp_strobe, exp_step);
            end
        end
    endtask

    task automatic test_hats();
        logic [3:0] exp_trig;
        logic       exp_choke;
        do_reset();
        write_bit(2, 2, 1'b1);
        write_bit(3, 2, 1'b1);
        write_bit(3, 5, 1'b1);
        bus.ticks_per_step = 16'd3;
        bus.run = 1'b1;
        tick();
        for (int n = 1; n <= 66; n++) begin
            tick();
            exp_trig  = 4'b0000;
            exp_choke = 1'b0;
            if (n == 7) begin
                exp_trig  = 4'b0100;
                exp_choke = 1'b1;
            end else if (n == 16 || n == 64) begin
                exp_trig = 4'b1000;
            end
            if (n == 55) begin
                // Second pass of step 2 with the closed hat muted.
                checks++;
                if (bus.trig[2:0] !== 3'b000 || bus.choke !== 1'b0) begin
                    failures++;
                    $display("FAIL chh_muted_no_choke trig=%b choke=%b expected trig[2:0]=000 choke=0",
                             bus.trig, bus.choke);
                end
            end else begin
                checks++;
                if (bus.trig !== exp_trig || bus.choke !== exp_choke) begin
                    failures++;
                    $display("FAIL hats n=%0d trig=%b choke=%b expected %b/%b",
                             n, bus.trig, bus.choke, exp_trig, exp_choke);
                end
            end
            if (n == 20) bus.mute = 4'b0100;
        end
        bus.mute = '0;
    endtask

    task automatic test_fast_tempo();
        logic [3:0] exp_trig;
        logic [3:0] exp_step;
        for (int t = 0; t < 2; t++) begin
            do_reset();
            write_bit(0, 0, 1'b1);
            bus.ticks_per_step = 16'(t);
            bus.run = 1'b1;
            tick();
            for (int n = 1; n <= 33; n++) begin
                tick();
                exp_trig = ((n - 1) % 16 == 0) ? 4'b0001 : 4'b0000;
                exp_step = 4'(n % 16);
                checks++;
                if (bus.trig !== exp_trig || bus.step_strobe !== 1'b1 || bus.step_idx !== exp_step) begin
                    failures++;
                    $display("FAIL fast_tempo tps=%0d n=%0d trig=%b strobe=%b step=%0d expected %b/1/%0d",
                             t, n, bus.trig, bus.step_strobe, bus.step_idx, exp_trig, exp_step);
                end
            end
        end
    endtask

    task automatic test_stop_restart();
        do_reset();
        write_bit(0, 0, 1'b1);
        write_bit(0, 7, 1'b1);
        write_bit(0, 8, 1'b1);
        bus.ticks_per_step = 16'd4;
        bus.run = 1'b1;
        tick();
        for (int n = 1; n <= 30; n++) begin
            tick();
            if (n == 29) begin
                checks++;
                if (bus.trig !== 4'b0001 || bus.step_idx !== 4'd7) begin
                    failures++;
                    $display("FAIL stop_step7_fire trig=%b step=%0d expected 0001/7", bus.trig, bus.step_idx);
                end
            end
        end
        bus.run = 1'b0;  // mid step 7
        for (int n = 0; n < 5; n++) begin
            tick();
            checks++;
            if (bus.trig !== 4'b0000 || bus.step_strobe !== 1'b0 || bus.step_idx !== 4'd0 || bus.choke !== 1'b0) begin
                failures++;
                $display("FAIL stopped n=%0d trig=%b strobe=%b step=%0d choke=%b expected 0000/0/0/0",
                         n, bus.trig, bus.step_strobe, bus.step_idx, bus.choke);
            end
        end
        bus.run = 1'b1;
        tick();
        checks++;
        if (bus.trig !== 4'b0000 || bus.step_strobe !== 1'b0) begin
            failures++;
            $display("FAIL restart_first_tick trig=%b strobe=%b expected 0000/0", bus.trig, bus.step_strobe);
        end
        tick();
        checks++;
        if (bus.trig !== 4'b0001 || bus.step_strobe !== 1'b1 || bus.step_idx !== 4'd0) begin
            failures++;
            $display("FAIL restart_step0 trig=%b strobe=%b step=%0d expected 0001/1/0",
                     bus.trig, bus.step_strobe, bus.step_idx);
        end
    endtask

    task automatic test_write_collision_mute();
        logic [3:0] exp_trig;
        do_reset();
        write_bit(0, 0, 1'b1);  // written while IDLE
        bus.ticks_per_step = 16'd4;
        bus.run = 1'b1;
        tick();
        // Snare bit lands on the same edge that fires step 0.
        bus.wr_en    = 1'b1;
        bus.wr_voice = 2'd1;
        bus.wr_step  = 4'd0;
        bus.wr_data  = 1'b1;
        for (int n = 1; n <= 130; n++) begin
            tick();
            bus.wr_en = 1'b0;
            exp_trig = 4'b0000;
            if (n == 1 || n == 129) exp_trig = 4'b0001;
            if (n == 65) exp_trig = 4'b0011;
            checks++;
            if (bus.trig !== exp_trig) begin
                failures++;
                $display("FAIL write_collision_mute n=%0d trig=%b expected %b", n, bus.trig, exp_trig);
            end
            if (n == 65) bus.mute = 4'b0010;
        end
        bus.mute = '0;
    endtask

    task automatic test_tempo_change_and_reset();
        do_reset();
        write_bit(0, 1, 1'b1);
        write_bit(0, 2, 1'b1);
        write_bit(0, 3, 1'b1);
        bus.ticks_per_step = 16'd100;
        bus.run = 1'b1;
        tick();
        for (int n = 1; n <= 50; n++) tick();  // tick_cnt now 50
        bus.ticks_per_step = 16'd2;
        tick();
        checks++;
        if (bus.step_idx !== 4'd1 || bus.trig !== 4'b0000 || bus.step_strobe !== 1'b0) begin
            failures++;
            $display("FAIL tempo_drop_step step=%0d trig=%b strobe=%b expected 1/0000/0",
                     bus.step_idx, bus.trig, bus.step_strobe);
        end
        tick();
        checks++;
        if (bus.trig !== 4'b0001 || bus.step_strobe !== 1'b1) begin
            failures++;
            $display("FAIL tempo_drop_fire1 trig=%b strobe=%b expected 0001/1", bus.trig, bus.step_strobe);
        end
        tick();
        checks++;
        if (bus.step_idx !== 4'd2 || bus.trig !== 4'b0000) begin
            failures++;
            $display("FAIL tempo_drop_gap step=%0d trig=%b expected 2/0000", bus.step_idx, bus.trig);
        end
        tick();
        checks++;
        if (bus.trig !== 4'b0001 || bus.step_strobe !== 1'b1) begin
            failures++;
            $display("FAIL tempo_drop_fire2 trig=%b strobe=%b expected 0001/1", bus.trig, bus.step_strobe);
        end
        tick();  // step 3 fires on the next edge
        rst = 1'b1;
        tick();
        checks++;
        if (bus.trig !== 4'b0000 || bus.choke !== 1'b0 || bus.step_strobe !== 1'b0 || bus.step_idx !== 4'd0) begin
            failures++;
            $display("FAIL reset_mid_play trig=%b choke=%b strobe=%b step=%0d expected 0000/0/0/0",
                     bus.trig, bus.choke, bus.step_strobe, bus.step_idx);
        end
        rst = 1'b0;
        bus.ticks_per_step = 16'd1;
        bus.run = 1'b1;
        tick();
        for (int n = 1; n <= 16; n++) begin
            tick();
            checks++;
            if (bus.trig !== 4'b0000 || bus.step_strobe !== 1'b1) begin
                failures++;
                $display("FAIL pattern_cleared n=%0d trig=%b strobe=%b expected 0000/1",
                         n, bus.trig, bus.step_strobe);
            end
        end
        bus.run = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_kick_pattern();
        test_hats();
        test_fast_tempo();
        test_stop_restart();
        test_write_collision_mute();
        test_tempo_change_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
